// File: rtl/rv32i_decode_stage.sv
// Registered RV32I decode stage: raw instruction word + PC in, decoded bundle out one cycle later
// over valid/ready, with a saturating count of illegal bundles handed to the consumer.
module rv32i_decode_stage #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [3:0]       out_class,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic             out_f7_alt,
    output logic [31:0]      out_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    localparam logic [6:0] F7_ZERO  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

    localparam logic [3:0] CLS_LUI   = 4'd0;
    localparam logic [3:0] CLS_AUIPC = 4'd1;
    localparam logic [3:0] CLS_JAL   = 4'd2;
    localparam logic [3:0] CLS_JALR  = 4'd3;
    localparam logic [3:0] CLS_BR    = 4'd4;
    localparam logic [3:0] CLS_LOAD  = 4'd5;
    localparam logic [3:0] CLS_STORE = 4'd6;
    localparam logic [3:0] CLS_IMM   = 4'd7;
    localparam logic [3:0] CLS_REG   = 4'd8;
    localparam logic [3:0] CLS_ILL   = 4'd15;

    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic        w_legal;
    logic [3:0]  w_class;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_funct3;
    logic        w_f7_alt;
    logic [31:0] w_imm;
    logic        w_accept;

    logic             r_valid;
    logic [31:0]      r_pc;
    logic [3:0]       r_class;
    logic [4:0]       r_rd, r_rs1, r_rs2;
    logic [2:0]       r_funct3;
    logic             r_f7_alt;
    logic [31:0]      r_imm;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cnt;

    assign w_op  = in_instr[6:0];
    assign w_f3  = in_instr[14:12];
    assign w_f7  = in_instr[31:25];

    assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                      in_instr[11:8], 1'b0};
    assign w_imm_u = {in_instr[31:12], 12'b0};
    assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                      in_instr[30:21], 1'b0};

    // Opcode classification and per-class funct legality
    always_comb begin
        w_class = CLS_ILL;
        w_legal = 1'b1;
        case (w_op)
            OP_LUI:   w_class = CLS_LUI;
            OP_AUIPC: w_class = CLS_AUIPC;
            OP_JAL:   w_class = CLS_JAL;
            OP_JALR: begin
                w_class = CLS_JALR;
                w_legal = (w_f3 == 3'b000);
            end
            OP_BR: begin
                w_class = CLS_BR;
                w_legal = (w_f3 != 3'b010) && (w_f3 != 3'b011);
            end
            OP_LOAD: begin
                w_class = CLS_LOAD;
                w_legal = (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
            end
            OP_STORE: begin
                w_class = CLS_STORE;
                w_legal = (w_f3 < 3'b011);
            end
            OP_IMM: begin
                w_class = CLS_IMM;
                if (w_f3 == 3'b001)
                    w_legal = (w_f7 == F7_ZERO);
                else if (w_f3 == 3'b101)
                    w_legal = (w_f7 == F7_ZERO) || (w_f7 == F7_ALT);
            end
            OP_REG: begin
                w_class = CLS_REG;
                w_legal = (w_f7 == F7_ZERO) ||
                          ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
            end
            default:  w_legal = 1'b0;
        endcase
        if (!w_legal)
            w_class = CLS_ILL;
    end

    // Field extraction: only fields the class actually uses are passed through
    always_comb begin
        w_rd     = 5'd0;
        w_rs1    = 5'd0;
        w_rs2    = 5'd0;
        w_funct3 = 3'd0;
        w_f7_alt = 1'b0;
        w_imm    = 32'd0;
        case (w_class)
            CLS_LUI, CLS_AUIPC: begin
                w_rd  = in_instr[11:7];
                w_imm = w_imm_u;
            end
            CLS_JAL: begin
                w_rd  = in_instr[11:7];
                w_imm = w_imm_j;
            end
            CLS_JALR, CLS_LOAD: begin
                w_rd     = in_instr[11:7];
                w_rs1    = in_instr[19:15];
                w_funct3 = w_f3;
                w_imm    = w_imm_i;
            end
            CLS_BR: begin
                w_rs1    = in_instr[19:15];
                w_rs2    = in_instr[24:20];
                w_funct3 = w_f3;
                w_imm    = w_imm_b;
            end
            CLS_STORE: begin
                w_rs1    = in_instr[19:15];
                w_rs2    = in_instr[24:20];
                w_funct3 = w_f3;
                w_imm    = w_imm_s;
            end
            CLS_IMM: begin
                w_rd     = in_instr[11:7];
                w_rs1    = in_instr[19:15];
                w_funct3 = w_f3;
                w_f7_alt = (w_f3 == 3'b101) ? in_instr[30] : 1'b0;
                w_imm    = w_imm_i;
            end
            CLS_REG: begin
                w_rd     = in_instr[11:7];
                w_rs1    = in_instr[19:15];
                w_rs2    = in_instr[24:20];
                w_funct3 = w_f3;
                w_f7_alt = in_instr[30];
            end
            default: ;
        endcase
    end

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Pipeline register; data holds on drain and stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_pc      <= 32'd0;
            r_class   <= 4'd0;
            r_rd      <= 5'd0;
            r_rs1     <= 5'd0;
            r_rs2     <= 5'd0;
            r_funct3  <= 3'd0;
            r_f7_alt  <= 1'b0;
            r_imm     <= 32'd0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_accept) begin
                r_valid   <= 1'b1;
                r_pc      <= in_pc;
                r_class   <= w_class;
                r_rd      <= w_rd;
                r_rs1     <= w_rs1;
                r_rs2     <= w_rs2;
                r_funct3  <= w_funct3;
                r_f7_alt  <= w_f7_alt;
                r_imm     <= w_imm;
                r_illegal <= !w_legal;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
            if (r_valid && out_ready && r_illegal && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_valid   = r_valid;
    assign out_pc      = r_pc;
    assign out_class   = r_class;
    assign out_rd      = r_rd;
    assign out_rs1     = r_rs1;
    assign out_rs2     = r_rs2;
    assign out_funct3  = r_funct3;
    assign out_f7_alt  = r_f7_alt;
    assign out_imm     = r_imm;
    assign out_illegal = r_illegal;
    assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Bench for rv32i_decode_stage: directed encodings, handshake stalls and a randomized stream
// checked against a rule-level decode model and a transaction-level pipeline model.
module tb_rv32i_decode_stage;

    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [31:0]      in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [3:0]       out_class;
    logic [4:0]       out_rd, out_rs1, out_rs2;
    logic [2:0]       out_funct3;
    logic             out_f7_alt;
    logic [31:0]      out_imm;
    logic             out_illegal;
    logic [CNT_W-1:0] illegal_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [3:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        f7a;
        logic [31:0] imm;
        logic        ill;
    } bundle_t;

    // Transaction-level model of the single output slot
    logic             m_valid;
    bundle_t          m_b;
    logic [31:0]      m_pc;
    logic [CNT_W-1:0] m_cnt;

    rv32i_decode_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_class(out_class), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_f7_alt(out_f7_alt), .out_imm(out_imm),
        .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Decode from the ISA rules, using arithmetic shifts for the sign-extended formats
    function automatic bundle_t model(input logic [31:0] w);
        bundle_t           b;
        logic [6:0]        f7;
        logic [2:0]        f3;
        logic              legal;
        logic [3:0]        cls;
        logic signed [31:0] s;
        b = '0;
        s = $signed(w);
        f3 = w[14:12];
        f7 = w[31:25];
        legal = 1'b1;
        cls = 4'd15;
        case (w[6:0])
            7'h37: cls = 4'd0;
            7'h17: cls = 4'd1;
            7'h6F: cls = 4'd2;
            7'h67: begin cls = 4'd3; legal = (f3 == 3'd0); end
            7'h63: begin cls = 4'd4; legal = !(f3 == 3'd2 || f3 == 3'd3); end
            7'h03: begin cls = 4'd5; legal = !(f3 == 3'd3 || f3 >= 3'd6); end
            7'h23: begin cls = 4'd6; legal = (f3 <= 3'd2); end
            7'h13: begin
                cls = 4'd7;
                if (f3 == 3'd1) legal = (f7 == 7'h00);
                if (f3 == 3'd5) legal = (f7 == 7'h00 || f7 == 7'h20);
            end
            7'h33: begin
                cls = 4'd8;
                legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            b.cls = 4'd15;
            b.ill = 1'b1;
            return b;
        end
        b.cls = cls;
        if (cls inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd8}) b.rd = w[11:7];
        if (cls inside {4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8}) begin
            b.rs1 = w[19:15];
            b.f3  = f3;
        end
        if (cls inside {4'd4, 4'd6, 4'd8}) b.rs2 = w[24:20];
        if (cls == 4'd8 || (cls == 4'd7 && f3 == 3'd5)) b.f7a = w[30];
        case (cls)
            4'd0, 4'd1:       b.imm = w & 32'hFFFF_F000;
            4'd2:             b.imm = 32'((s >>> 31) <<< 20) | (32'(w[19:12]) << 12) |
                                      (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
            4'd3, 4'd5, 4'd7: b.imm = 32'(s >>> 20);
            4'd4:             b.imm = 32'((s >>> 31) <<< 12) | (32'(w[7]) << 11) |
                                      (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
            4'd6:             b.imm = 32'((s >>> 25) <<< 5) | 32'(w[11:7]);
            default:          b.imm = 32'd0;
        endcase
        return b;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [9];
        logic [31:0] w;
        int          k;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        w = $urandom;
        k = $urandom_range(0, 11);
        if (k < 9) w[6:0] = ops[k];
        if ($urandom_range(0, 2) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h20;
        return w;
    endfunction

    task automatic model_edge(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                              input logic rdy);
        logic acc, ho;
        acc = v && (!m_valid || rdy);
        ho  = m_valid && rdy;
        if (ho && m_b.ill && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
        if (acc) begin
            m_b = model(instr);
            m_pc = pc;
            m_valid = 1'b1;
        end else if (ho) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic rdy);
        in_valid = v; in_instr = instr; in_pc = pc; out_ready = rdy;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        rst_n = 1'b0;
        #7;
        rst_n = 1'b1;
        @(posedge clk); #1;
        m_valid = 1'b0; m_b = '0; m_pc = '0; m_cnt = '0;
    endtask

    function automatic bundle_t observed();
        return {out_class, out_rd, out_rs1, out_rs2, out_funct3, out_f7_alt, out_imm, out_illegal};
    endfunction

    task automatic test_reset();
        in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        rst_n = 1'b0;
        #12;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0h exp=0", out_valid); end
        n_tests++; if (observed() !== bundle_t'(0) || out_pc !== 32'd0) begin n_fail++; $display("FAIL reset_data got=%h pc=%h exp=0", observed(), out_pc); end
        n_tests++; if (illegal_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", illegal_cnt); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid got=%0h exp=0", out_valid); end
    endtask

    task automatic test_illegal_cnt();
        step(1'b1, 32'h0000_0000, 32'h200, 1'b0);
        n_tests++; if (out_valid !== 1'b1 || out_class !== 4'd15 || out_illegal !== 1'b1 || out_imm !== 32'd0) begin n_fail++; $display("FAIL ill_zero got v=%0h cls=%0d ill=%0h imm=%h exp 1/15/1/0", out_valid, out_class, out_illegal, out_imm); end
        n_tests++; if (illegal_cnt !== 16'd0) begin n_fail++; $display("FAIL ill_cnt0 got=%0d exp=0", illegal_cnt); end
        step(1'b1, 32'h0000_007F, 32'h204, 1'b1);
        n_tests++; if (illegal_cnt !== 16'd1) begin n_fail++; $display("FAIL ill_cnt1 got=%0d exp=1", illegal_cnt); end
        n_tests++; if (out_class !== 4'd15 || out_pc !== 32'h204 || out_rd !== 5'd0 || out_rs1 !== 5'd0) begin n_fail++; $display("FAIL ill_7f got cls=%0d pc=%h rd=%0d rs1=%0d exp 15/204/0/0", out_class, out_pc, out_rd, out_rs1); end
        step(1'b0, 32'h0, 32'h0, 1'b1);
        n_tests++; if (illegal_cnt !== 16'd2 || out_valid !== 1'b0) begin n_fail++; $display("FAIL ill_cnt2 got cnt=%0d v=%0h exp 2/0", illegal_cnt, out_valid); end
    endtask

    task automatic test_directed();
        step(1'b1, 32'hFFF0_0093, 32'h100, 1'b1);
        n_tests++; if (out_valid !== 1'b1 || out_class !== 4'd7 || out_rd !== 5'd1 || out_rs1 !== 5'd0 || out_imm !== 32'hFFFF_FFFF || out_illegal !== 1'b0 || out_pc !== 32'h100) begin n_fail++; $display("FAIL addi got v=%0h cls=%0d rd=%0d rs1=%0d imm=%h ill=%0h pc=%h", out_valid, out_class, out_rd, out_rs1, out_imm, out_illegal, out_pc); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL addi_in_ready got=%0h exp=1", in_ready); end
        step(1'b1, 32'hFE20_8EE3, 32'h104, 1'b1);
        n_tests++; if (out_valid !== 1'b1 || out_class !== 4'd4 || out_rd !== 5'd0 || out_rs1 !== 5'd1 || out_rs2 !== 5'd2 || out_imm !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL beq got v=%0h cls=%0d rd=%0d rs1=%0d rs2=%0d imm=%h", out_valid, out_class, out_rd, out_rs1, out_rs2, out_imm); end
        step(1'b1, 32'h4020_81B3, 32'h108, 1'b1);
        n_tests++; if (out_class !== 4'd8 || out_rd !== 5'd3 || out_f7_alt !== 1'b1 || out_rs1 !== 5'd1 || out_rs2 !== 5'd2 || out_imm !== 32'd0) begin n_fail++; $display("FAIL sub got cls=%0d rd=%0d f7=%0h rs1=%0d rs2=%0d imm=%h", out_class, out_rd, out_f7_alt, out_rs1, out_rs2, out_imm); end
        step(1'b1, 32'h4020_91B3, 32'h10C, 1'b1);
        n_tests++; if (out_class !== 4'd15 || out_illegal !== 1'b1 || out_rd !== 5'd0 || out_rs2 !== 5'd0 || out_funct3 !== 3'd0 || out_f7_alt !== 1'b0 || out_pc !== 32'h10C) begin n_fail++; $display("FAIL sll_alt got cls=%0d ill=%0h rd=%0d rs2=%0d f3=%0d f7=%0h pc=%h", out_class, out_illegal, out_rd, out_rs2, out_funct3, out_f7_alt, out_pc); end
        step(1'b0, 32'h0, 32'h0, 1'b1);
        n_tests++; if (out_valid !== 1'b0 || out_pc !== 32'h10C || out_class !== 4'd15) begin n_fail++; $display("FAIL drain_hold got v=%0h pc=%h cls=%0d exp 0/10c/15", out_valid, out_pc, out_class); end
    endtask

    task automatic test_stall_stream();
        logic [31:0] words [8];
        logic [31:0] q [$];
        logic [31:0] exp_pc, snap_pc;
        bundle_t     snap;
        logic        v, rdy, stalled, acc;
        int          acc_i, ho_n, c;
        acc_i = 0; ho_n = 0; c = 0;
        do_reset();
        for (int k = 0; k < 8; k++) words[k] = rand_instr();
        while ((acc_i < 8 || m_valid) && c < 40) begin
            v   = (acc_i < 8);
            rdy = !(c >= 3 && c <= 5);
            in_valid = v;
            in_instr = v ? words[acc_i] : 32'd0;
            in_pc = 32'h1000 + 32'(4 * acc_i);
            out_ready = rdy;
            #1;
            n_tests++; if (in_ready !== (!m_valid || rdy)) begin n_fail++; $display("FAIL stall_in_ready c=%0d got=%0h exp=%0h", c, in_ready, !m_valid || rdy); end
            stalled = m_valid && !rdy;
            snap = observed();
            snap_pc = out_pc;
            if (m_valid && rdy) begin
                exp_pc = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
                ho_n++;
                n_tests++; if (out_pc !== exp_pc) begin n_fail++; $display("FAIL stall_order c=%0d got=%h exp=%h", c, out_pc, exp_pc); end
            end
            acc = v && (!m_valid || rdy);
            if (acc) q.push_back(in_pc);
            model_edge(v, in_instr, in_pc, rdy);
            if (acc) acc_i++;
            @(posedge clk); #1;
            c++;
            n_tests++; if (out_valid !== m_valid || observed() !== m_b || out_pc !== m_pc) begin n_fail++; $display("FAIL stall_bundle c=%0d got v=%0h b=%h pc=%h exp v=%0h b=%h pc=%h", c, out_valid, observed(), out_pc, m_valid, m_b, m_pc); end
            n_tests++; if (illegal_cnt !== m_cnt) begin n_fail++; $display("FAIL stall_cnt c=%0d got=%0d exp=%0d", c, illegal_cnt, m_cnt); end
            if (stalled) begin
                n_tests++; if (observed() !== snap || out_pc !== snap_pc || out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_frozen c=%0d got b=%h pc=%h exp b=%h pc=%h", c, observed(), out_pc, snap, snap_pc); end
            end
        end
        n_tests++; if (acc_i != 8 || ho_n != 8 || q.size() != 0) begin n_fail++; $display("FAIL stall_complete got acc=%0d ho=%0d left=%0d exp 8/8/0", acc_i, ho_n, q.size()); end
    endtask

    task automatic test_random();
        logic v, rdy;
        logic [31:0] w, pc;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            w   = rand_instr();
            pc  = $urandom & 32'hFFFF_FFFC;
            in_valid = v; in_instr = w; in_pc = pc; out_ready = rdy;
            #1;
            n_tests++; if (in_ready !== (!m_valid || rdy)) begin n_fail++; $display("FAIL rand_in_ready c=%0d got=%0h exp=%0h", c, in_ready, !m_valid || rdy); end
            model_edge(v, w, pc, rdy);
            @(posedge clk); #1;
            n_tests++; if (out_valid !== m_valid || observed() !== m_b || out_pc !== m_pc) begin n_fail++; $display("FAIL rand_bundle c=%0d instr=%h got v=%0h b=%h pc=%h exp v=%0h b=%h pc=%h", c, w, out_valid, observed(), out_pc, m_valid, m_b, m_pc); end
            n_tests++; if (illegal_cnt !== m_cnt) begin n_fail++; $display("FAIL rand_cnt c=%0d got=%0d exp=%0d", c, illegal_cnt, m_cnt); end
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        step(1'b1, 32'h0000_0000, 32'h300, 1'b1);
        step(1'b1, 32'hFFF0_0093, 32'h304, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0);
        n_tests++; if (out_valid !== 1'b1 || illegal_cnt !== 16'd1 || out_class !== 4'd7) begin n_fail++; $display("FAIL midrst_pre got v=%0h cnt=%0d cls=%0d exp 1/1/7", out_valid, illegal_cnt, out_class); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || illegal_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_async got v=%0h cnt=%0d exp 0/0", out_valid, illegal_cnt); end
        n_tests++; if (observed() !== bundle_t'(0) || out_pc !== 32'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_data got b=%h pc=%h rdy=%0h exp 0/0/1", observed(), out_pc, in_ready); end
        #1;
        rst_n = 1'b1;
        step(1'b0, 32'h0, 32'h0, 1'b1);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_after got v=%0h exp=0", out_valid); end
    endtask

    initial begin
        m_valid = 1'b0; m_b = '0; m_pc = '0; m_cnt = '0;
        test_reset();
        test_illegal_cnt();
        test_directed();
        test_stall_stream();
        test_random();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
